// File: rtl/pc_run_controller.sv
// -----------------------------------------------------------------------------
// pc_run_controller
//
// Run/halt/single-step sequencer for the program counter of the single-cycle
// CPU. It turns the clock-divider tick into pc_clock_enable pulses, honours
// the debounced run/step/halt buttons, stops on a PC breakpoint or on a halt
// instruction, and counts the enables it has issued.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   tick             one-cycle step-rate pulse from the clock divider
//   btn_run          debounced level, rising edge requests RUN
//   btn_step         debounced level, rising edge requests one instruction
//   btn_halt         debounced level, rising edge requests HALT
//   halt_instr       decoder flag: current instruction is a halt/syscall
//   bp_enable        breakpoint armed
//   bp_addr          breakpoint PC value
//   pc               current PC from the program counter
//   pc_clock_enable  advance strobe to the PC
//   state            0=HALT, 1=RUN, 2=STEP, 3=BREAK (also the debug view)
//   bp_hit           sticky: stopped at a breakpoint
//   instr_count      number of issued pc_clock_enable pulses (saturating)
//
// Handshake: pc_clock_enable is a single-cycle strobe with no back-pressure.
// The PC advances on every rising edge where it is 1; there is no ready.
// -----------------------------------------------------------------------------
module pc_run_controller #(
   parameter int ADDR_WIDTH   = 32,
   parameter int CNT_WIDTH    = 32,
   parameter bit RUN_ON_RESET = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic                  btn_run,
   input  logic                  btn_step,
   input  logic                  btn_halt,
   input  logic                  halt_instr,
   input  logic                  bp_enable,
   input  logic [ADDR_WIDTH-1:0] bp_addr,
   input  logic [ADDR_WIDTH-1:0] pc,
   output logic                  pc_clock_enable,
   output logic [1:0]            state,
   output logic                  bp_hit,
   output logic [CNT_WIDTH-1:0]  instr_count
);

   localparam logic [1:0] ST_HALT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STEP  = 2'd2;
   localparam logic [1:0] ST_BREAK = 2'd3;

   localparam logic [1:0] ST_RESET = RUN_ON_RESET ? ST_RUN : ST_HALT;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]           state_q, state_d;
   logic                 bp_hit_q, bp_hit_d;
   logic                 skip_bp_q, skip_bp_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 run_q, step_q, halt_q;

   logic run_press, step_press, halt_press;
   logic bp_block, block, active;

   // One registered copy per button; a held level yields a single press.
   assign run_press  = btn_run  & ~run_q;
   assign step_press = btn_step & ~step_q;
   assign halt_press = btn_halt & ~halt_q;

   // skip_bp lets the instruction sitting on the breakpoint execute once
   // after a resume; it is cleared by the first enable that goes out.
   assign bp_block = bp_enable & (pc == bp_addr) & ~skip_bp_q;
   assign block    = bp_block | halt_instr;
   assign active   = (state_q == ST_RUN) | (state_q == ST_STEP);

   // Gated by rst_n so a RUN reset state cannot leak an enable during reset.
   assign pc_clock_enable = rst_n & tick & active & ~block;

   always_comb begin
      state_d   = state_q;
      bp_hit_d  = bp_hit_q;
      skip_bp_d = skip_bp_q;

      if (pc_clock_enable) begin
         skip_bp_d = 1'b0;
      end

      case (state_q)
         ST_HALT, ST_BREAK: begin
            // Halt outranks step outranks run; a halt press here is a no-op.
            if (halt_press) begin
               state_d = state_q;
            end else if (step_press) begin
               state_d   = ST_STEP;
               skip_bp_d = 1'b1;
               bp_hit_d  = 1'b0;
            end else if (run_press) begin
               state_d   = ST_RUN;
               skip_bp_d = 1'b1;
               bp_hit_d  = 1'b0;
            end
         end
         ST_RUN: begin
            // A step press while running is ignored.
            if (halt_press) begin
               state_d = ST_HALT;
            end else if (tick && bp_block) begin
               state_d  = ST_BREAK;
               bp_hit_d = 1'b1;
            end else if (tick && halt_instr) begin
               state_d = ST_HALT;
            end
         end
         ST_STEP: begin
            // Any tick ends the step, whether or not it issued an enable.
            if (halt_press || tick) begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RESET;
         bp_hit_q  <= 1'b0;
         skip_bp_q <= 1'b1;
         cnt_q     <= '0;
         run_q     <= 1'b0;
         step_q    <= 1'b0;
         halt_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bp_hit_q  <= bp_hit_d;
         skip_bp_q <= skip_bp_d;
         run_q     <= btn_run;
         step_q    <= btn_step;
         halt_q    <= btn_halt;
         // Saturating count: holds at all-ones instead of wrapping.
         if (pc_clock_enable && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end
   end

   assign state       = state_q;
   assign bp_hit      = bp_hit_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_run_controller.sv
// -----------------------------------------------------------------------------
// tb_pc_run_controller
//
// Directed bench for pc_run_controller. The main instance (RUN_ON_RESET=0,
// 32-bit counter) is driven through reset, run, breakpoint, step, halt and
// coincidence scenarios; the bench owns the PC and advances it by 4 on each
// enable it expects. A second instance (RUN_ON_RESET=1, 4-bit counter) sees
// the same tick and reset and runs freely, so its counter reaches saturation.
// Expected enables are queued by the driver and popped by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_pc_run_controller;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        btn_run, btn_step, btn_halt;
  logic        halt_instr;
  logic        bp_enable;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        pc_clock_enable;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] instr_count;

  logic        s_zero;
  logic [31:0] s_zero_addr;
  logic        s_en;
  logic [1:0]  s_state;
  logic        s_bp_hit;
  logic [3:0]  s_cnt;

  int checks;
  int failures;

  logic [63:0] exp_q[$];
  logic [31:0] exp_cnt;
  logic [3:0]  s_exp;

  pc_run_controller #(
    .ADDR_WIDTH   (32),
    .CNT_WIDTH    (32),
    .RUN_ON_RESET (1'b0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .btn_run         (btn_run),
    .btn_step        (btn_step),
    .btn_halt        (btn_halt),
    .halt_instr      (halt_instr),
    .bp_enable       (bp_enable),
    .bp_addr         (bp_addr),
    .pc              (pc),
    .pc_clock_enable (pc_clock_enable),
    .state           (state),
    .bp_hit          (bp_hit),
    .instr_count     (instr_count)
  );

  pc_run_controller #(
    .ADDR_WIDTH   (32),
    .CNT_WIDTH    (4),
    .RUN_ON_RESET (1'b1)
  ) dut_sat (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .btn_run         (s_zero),
    .btn_step        (s_zero),
    .btn_halt        (s_zero),
    .halt_instr      (s_zero),
    .bp_enable       (s_zero),
    .bp_addr         (s_zero_addr),
    .pc              (pc),
    .pc_clock_enable (s_en),
    .state           (s_state),
    .bp_hit          (s_bp_hit),
    .instr_count     (s_cnt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- compare helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle with tick=t. When an enable is expected, the current PC
  // and pre-increment count are queued, and the PC steps by 4 afterwards.
  task automatic cyc(input logic t, input logic exp_en);
    tick = t;
    if (exp_en) begin
      exp_q.push_back({pc, exp_cnt});
      exp_cnt = exp_cnt + 32'd1;
    end
    if (t && rst_n) begin
      s_exp = (s_exp == 4'hF) ? s_exp : s_exp + 4'd1;
    end
    @(posedge clk);
    #1;
    tick = 1'b0;
    if (exp_en) pc = pc + 32'd4;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (pc_clock_enable) begin
      chk("enable_with_tick", {63'd0, tick}, 64'd1);
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_enable: got enable at pc 0x%0h expected none at %0t", pc, $time);
      end else begin
        e = exp_q.pop_front();
        chk("enable_pc", {32'd0, pc}, {32'd0, e[63:32]});
        chk("enable_count", {32'd0, instr_count}, {32'd0, e[31:0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    exp_cnt     = 32'd0;
    s_exp       = 4'd0;
    s_zero      = 1'b0;
    s_zero_addr = 32'd0;
    rst_n       = 1'b0;
    tick        = 1'b1;
    btn_run     = 1'b0;
    btn_step    = 1'b0;
    btn_halt    = 1'b0;
    halt_instr  = 1'b0;
    bp_enable   = 1'b0;
    bp_addr     = 32'd0;
    pc          = 32'd0;

    // Reset with tick high: nothing may be enabled.
    @(negedge clk);
    chk("reset_state", {62'd0, state}, 64'd0);
    chk("reset_enable", {63'd0, pc_clock_enable}, 64'd0);
    chk("reset_count", {32'd0, instr_count}, 64'd0);
    chk("reset_bp_hit", {63'd0, bp_hit}, 64'd0);
    chk("sat_reset_state", {62'd0, s_state}, 64'd1);
    chk("sat_reset_enable", {63'd0, s_en}, 64'd0);
    @(posedge clk);
    #1;
    tick  = 1'b0;
    rst_n = 1'b1;

    // Ticks in HALT do nothing.
    repeat (5) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
    chk("halt_ticks_state", {62'd0, state}, 64'd0);
    chk("halt_ticks_count", {32'd0, instr_count}, 64'd0);
    chk("sat_count_5", {60'd0, s_cnt}, 64'd5);

    // RUN, a tick every 4 cycles, 10 ticks.
    btn_run = 1'b1;
    cyc(1'b0, 1'b0);
    chk("run_state", {62'd0, state}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1);
      repeat (3) cyc(1'b0, 1'b0);
    end
    btn_run = 1'b0;
    chk("run_count", {32'd0, instr_count}, 64'd10);
    chk("run_state_after", {62'd0, state}, 64'd1);
    chk("sat_count_15", {60'd0, s_cnt}, 64'd15);

    // Breakpoint at 0x0C: PC jumps to 0, runs 0,4,8, then blocks at 0x0C.
    pc        = 32'h0;
    bp_enable = 1'b1;
    bp_addr   = 32'h0000000C;
    repeat (3) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("bp_state", {62'd0, state}, 64'd3);
    chk("bp_hit_set", {63'd0, bp_hit}, 64'd1);
    chk("bp_count", {32'd0, instr_count}, 64'd13);
    cyc(1'b1, 1'b0);
    chk("bp_stays", {62'd0, state}, 64'd3);

    // Resume: the breakpointed instruction executes once.
    btn_run = 1'b1;
    cyc(1'b0, 1'b0);
    chk("resume_state", {62'd0, state}, 64'd1);
    chk("resume_bp_hit", {63'd0, bp_hit}, 64'd0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    btn_run = 1'b0;
    chk("resume_count", {32'd0, instr_count}, 64'd15);

    // Exact compare: 0x0D must not match 0x0C.
    pc = 32'h0000000D;
    cyc(1'b1, 1'b1);
    chk("exact_cmp_state", {62'd0, state}, 64'd1);

    // Back at 0x0C the breakpoint blocks again (skip was cleared).
    pc = 32'h0000000C;
    cyc(1'b1, 1'b0);
    chk("rehit_state", {62'd0, state}, 64'd3);
    btn_halt = 1'b1;
    cyc(1'b0, 1'b0);
    chk("halt_in_break", {62'd0, state}, 64'd3);
    chk("halt_in_break_hit", {63'd0, bp_hit}, 64'd1);
    btn_halt = 1'b0;

    // Step out of BREAK: one enable at 0x0C, then HALT.
    btn_step = 1'b1;
    cyc(1'b0, 1'b0);
    chk("step_from_bp", {62'd0, state}, 64'd2);
    chk("step_from_bp_hit", {63'd0, bp_hit}, 64'd0);
    cyc(1'b1, 1'b1);
    chk("step_from_bp_done", {62'd0, state}, 64'd0);
    btn_step  = 1'b0;
    bp_enable = 1'b0;
    cyc(1'b0, 1'b0);

    // btn_step held 20 cycles with 3 ticks: exactly one enable.
    btn_step = 1'b1;
    cyc(1'b0, 1'b0);
    chk("held_step_state", {62'd0, state}, 64'd2);
    for (int i = 0; i < 19; i++) begin
      cyc((i == 2) || (i == 8) || (i == 14), i == 2);
    end
    chk("held_step_done", {62'd0, state}, 64'd0);
    chk("held_step_count", {32'd0, instr_count}, 64'd18);
    btn_step = 1'b0;
    cyc(1'b0, 1'b0);

    // Halt press coinciding with tick in RUN: enable still issued.
    btn_run = 1'b1;
    cyc(1'b0, 1'b0);
    btn_run = 1'b0;
    cyc(1'b0, 1'b0);
    btn_halt = 1'b1;
    cyc(1'b1, 1'b1);
    chk("halt_tick_state", {62'd0, state}, 64'd0);
    chk("halt_tick_count", {32'd0, instr_count}, 64'd19);
    btn_halt = 1'b0;
    cyc(1'b0, 1'b0);

    // Halt and step rise together in RUN: halt wins, no step follows.
    btn_run = 1'b1;
    cyc(1'b0, 1'b0);
    btn_run = 1'b0;
    cyc(1'b0, 1'b0);
    chk("coin_pre_state", {62'd0, state}, 64'd1);
    btn_halt = 1'b1;
    btn_step = 1'b1;
    cyc(1'b0, 1'b0);
    chk("coin_state", {62'd0, state}, 64'd0);
    cyc(1'b1, 1'b0);
    chk("coin_no_step", {62'd0, state}, 64'd0);
    btn_halt = 1'b0;
    btn_step = 1'b0;
    cyc(1'b0, 1'b0);

    // halt_instr in RUN: only acts on a tick, with no enable.
    btn_run = 1'b1;
    cyc(1'b0, 1'b0);
    btn_run = 1'b0;
    halt_instr = 1'b1;
    cyc(1'b0, 1'b0);
    chk("hi_run_wait", {62'd0, state}, 64'd1);
    cyc(1'b1, 1'b0);
    chk("hi_run_state", {62'd0, state}, 64'd0);
    halt_instr = 1'b0;

    // halt_instr in STEP: no enable, back to HALT.
    btn_step = 1'b1;
    cyc(1'b0, 1'b0);
    chk("hi_step_enter", {62'd0, state}, 64'd2);
    btn_step   = 1'b0;
    halt_instr = 1'b1;
    cyc(1'b1, 1'b0);
    chk("hi_step_state", {62'd0, state}, 64'd0);
    chk("hi_step_count", {32'd0, instr_count}, 64'd19);
    halt_instr = 1'b0;

    // Asynchronous reset between edges while running.
    btn_run = 1'b1;
    cyc(1'b0, 1'b0);
    btn_run = 1'b0;
    cyc(1'b1, 1'b1);
    chk("pre_reset_count", {32'd0, instr_count}, 64'd20);
    chk("pre_reset_state", {62'd0, state}, 64'd1);
    tick  = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("async_state", {62'd0, state}, 64'd0);
    chk("async_count", {32'd0, instr_count}, 64'd0);
    chk("async_enable", {63'd0, pc_clock_enable}, 64'd0);
    chk("async_sat_count", {60'd0, s_cnt}, 64'd0);
    chk("async_sat_state", {62'd0, s_state}, 64'd1);
    chk("async_sat_enable", {63'd0, s_en}, 64'd0);
    exp_cnt = 32'd0;
    s_exp   = 4'd0;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    chk("post_reset_state", {62'd0, state}, 64'd0);
    chk("post_reset_count", {32'd0, instr_count}, 64'd0);
    chk("post_reset_sat", {60'd0, s_cnt}, {60'd0, s_exp});

    repeat (2) cyc(1'b0, 1'b0);
    chk("queue_drained", {32'd0, exp_q.size()}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
